// File: rtl/calc_pkg.sv
// calc_pkg: shared keypad scanner states, raw key codes and matrix width.
package calc_pkg;
    localparam int KP_W = 4;
    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} scan_state_e;
    localparam logic [3:0] KEY_R0C0 = 4'd0,  KEY_R0C1 = 4'd1,  KEY_R0C2 = 4'd2,  KEY_R0C3 = 4'd3;
    localparam logic [3:0] KEY_R1C0 = 4'd4,  KEY_R1C1 = 4'd5,  KEY_R1C2 = 4'd6,  KEY_R1C3 = 4'd7;
    localparam logic [3:0] KEY_R2C0 = 4'd8,  KEY_R2C1 = 4'd9,  KEY_R2C2 = 4'd10, KEY_R2C3 = 4'd11;
    localparam logic [3:0] KEY_R3C0 = 4'd12, KEY_R3C1 = 4'd13, KEY_R3C2 = 4'd14, KEY_R3C3 = 4'd15;
    function automatic logic [3:0] key_code_of(input logic [1:0] row, input logic [1:0] col);
        return {row, col};
    endfunction
endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchronizer for asynchronous inputs, resets to all-ones.
module sync2 #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] s1_q, s2_q;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q <= '1;
            s2_q <= '1;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end
    assign q = s2_q;
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: column scan, debounce and one-strobe-per-press code capture for a 4x4 keypad.
module keypad_scanner
    import calc_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CYC = 200000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [KP_W-1:0] row_n,
    output logic [KP_W-1:0] col_n,
    output logic            key_valid,
    output logic [3:0]      key_code,
    output logic            key_held
);
    localparam int CMAX = (SCAN_DIV > DEBOUNCE_CYC) ? SCAN_DIV : DEBOUNCE_CYC;
    localparam int CW = $clog2(CMAX);
    localparam logic [CW-1:0] SCAN_END = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DEB_END = CW'(DEBOUNCE_CYC - 1);

    scan_state_e     state_q, state_d;
    logic [1:0]      col_q, col_d, row_q, row_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            key_valid_q, key_valid_d, key_held_q, key_held_d;
    logic [3:0]      key_code_q, key_code_d;
    logic [KP_W-1:0] row_s;
    logic [1:0]      low_row;
    logic            row_up;

    sync2 #(.W(KP_W)) u_sync (.clk(clk), .rst_n(rst_n), .d(row_n), .q(row_s));

    assign low_row = !row_s[0] ? 2'd0 : !row_s[1] ? 2'd1 : !row_s[2] ? 2'd2 : 2'd3;
    assign row_up  = row_s[row_q];

    // one shared counter: dwell in SCAN, stable-cycle count in DEBOUNCE/RELEASE
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        cnt_d       = cnt_q + 1'b1;
        key_valid_d = 1'b0;
        key_code_d  = key_code_q;
        key_held_d  = key_held_q;
        unique case (state_q)
            SCAN: if (cnt_q == SCAN_END) begin
                cnt_d = '0;
                if (row_s != '1) begin
                    state_d = DEBOUNCE;
                    row_d   = low_row;
                end else begin
                    col_d = col_q + 2'd1;
                end
            end
            DEBOUNCE: if (row_up) begin
                state_d = SCAN;
                cnt_d   = '0;
            end else if (cnt_q == DEB_END) begin
                state_d     = HELD;
                key_valid_d = 1'b1;
                key_code_d  = key_code_of(row_q, col_q);
                key_held_d  = 1'b1;
            end
            HELD: begin
                cnt_d   = '0;
                state_d = row_up ? RELEASE : HELD;
            end
            RELEASE: if (!row_up) begin
                cnt_d = '0;
            end else if (cnt_q == DEB_END) begin
                state_d    = SCAN;
                cnt_d      = '0;
                key_held_d = 1'b0;
                col_d      = col_q + 2'd1;
            end
            default: state_d = SCAN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= SCAN;
            col_q       <= '0;
            row_q       <= '0;
            cnt_q       <= '0;
            key_valid_q <= 1'b0;
            key_code_q  <= KEY_R0C0;
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            cnt_q       <= cnt_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            key_held_q  <= key_held_d;
        end
    end

    assign col_n     = ~(4'b0001 << col_q);
    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;
    assign key_held  = key_held_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: randomized keypad presses against a matrix model, scoreboarded strobes.
module tb_keypad_scanner;
    localparam int SD = 4;
    localparam int DC = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  row_n, col_n, key_code;
    logic        key_valid, key_held;
    logic [15:0] pressed = '0;
    int          total = 0, bad = 0, cyc = 0, col_chg = 0;
    int          exp_q[$];
    bit          lat_chk = 0, v_prev = 0;
    logic [3:0]  col_prev = 4'hE;

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CYC(DC)) dut (
        .clk(clk), .rst_n(rst_n), .row_n(row_n), .col_n(col_n),
        .key_valid(key_valid), .key_code(key_code), .key_held(key_held)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // a pressed key pulls its row low only while its column is driven low
    always_comb begin
        row_n = '1;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
    end

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : mon
        int e;
        if (col_n != col_prev) begin
            col_chg  = cyc;
            col_prev = col_n;
        end
        if (rst_n && key_valid) begin
            check("strobe_width", int'(v_prev), 0);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_strobe: got code %0d expected no strobe", key_code);
            end else begin
                e = exp_q.pop_front();
                check("key_code", key_code, e);
                check("held_at_strobe", key_held, 1);
                if (lat_chk) check("press_latency", cyc - col_chg, SD + DC);
            end
        end
        v_prev = rst_n && key_valid;
    end

    task automatic wait_held(input logic val, input string nm);
        for (int i = 0; i < 200 && key_held != val; i++) tick;
        check(nm, key_held, val);
    endtask

    task automatic press_cycle(input int c, input logic [3:0] mask, input int bounce,
                               input int hold, input bit other);
        int         r, t0, oc;
        logic [3:0] ecol;
        r = 0;
        while (!mask[r]) r++;
        exp_q.push_back(r * 4 + c);
        lat_chk = (bounce == 0) && col_n[c];
        for (int i = 0; i < bounce; i++) begin
            for (int k = 0; k < 4; k++) pressed[k*4+c] = mask[k] && (i % 2 == 0);
            tick;
        end
        for (int k = 0; k < 4; k++) pressed[k*4+c] = mask[k];
        wait_held(1'b1, "held_rise");
        if (other) begin
            oc = (c + 1 + $urandom_range(2)) % 4;
            pressed[$urandom_range(3)*4+oc] = 1'b1;
        end
        ecol = 4'b0001 << c;
        ecol = ~ecol;
        repeat (hold) begin
            tick;
            check("col_frozen", col_n, ecol);
            check("held_during", key_held, 1);
        end
        t0 = cyc;
        pressed = '0;
        wait_held(1'b0, "held_fall");
        check("release_latency", cyc - t0, 3 + DC);
        ecol = 4'b0001 << ((c + 1) % 4);
        ecol = ~ecol;
        check("col_after_release", col_n, ecol);
    endtask

    initial begin
        logic [3:0] ecol;
        repeat (3) tick;
        check("rst_col_n", col_n, 4'hE);
        check("rst_valid", key_valid, 0);
        check("rst_code", key_code, 0);
        check("rst_held", key_held, 0);
        rst_n = 1'b1;
        for (int k = 0; k < 32; k++) begin
            ecol = 4'b0001 << ((k / 4) % 4);
            ecol = ~ecol;
            check("idle_scan", col_n, ecol);
            tick;
        end
        press_cycle(1, 4'b0100, 0, 40, 1'b0);
        press_cycle(3, 4'b0001, 10, 5, 1'b0);
        press_cycle(0, 4'b1010, 0, 5, 1'b0);
        press_cycle(2, 4'b0010, 0, 100, 1'b1);
        for (int i = 0; i < 20 && !col_n[2]; i++) tick;
        lat_chk = 1'b0;
        pressed[2] = 1'b1;
        for (int i = 0; i < 40 && col_n[2]; i++) tick;
        repeat (4) tick;
        rst_n = 1'b0;
        tick;
        check("midrst_col_n", col_n, 4'hE);
        check("midrst_valid", key_valid, 0);
        check("midrst_code", key_code, 0);
        check("midrst_held", key_held, 0);
        pressed = '0;
        rst_n = 1'b1;
        repeat (30) tick;
        for (int n = 0; n < 12; n++) begin
            press_cycle($urandom_range(3), 4'($urandom_range(1, 15)),
                        $urandom_range(1) ? 0 : $urandom_range(2, 9),
                        $urandom_range(3, 40), 1'($urandom_range(1)));
            repeat ($urandom_range(12)) tick;
        end
        repeat (20) tick;
        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
